// File: rtl/mem_arb_if.sv
// mem_arb_if -- bus bundle around the two-master memory arbiter.
//   m0_* / m1_* : Wishbone-style request/response ports for the CPU (m0)
//                 and the display/DMA engine (m1).
//   s_*         : single port towards the SRAM/flash memory controller.
// Modports:
//   slave  : the arbiter's view (it is the slave of both masters and drives
//            the controller-facing s_* signals).
//   master : the environment's view (masters plus memory controller).
interface mem_arb_if;
  logic [19:0] m0_adr_i;
  logic [15:0] m0_dat_i;
  logic [15:0] m0_dat_o;
  logic        m0_we_i;
  logic        m0_byte_i;
  logic        m0_stb_i;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic [19:0] m1_adr_i;
  logic [15:0] m1_dat_i;
  logic [15:0] m1_dat_o;
  logic        m1_we_i;
  logic        m1_byte_i;
  logic        m1_stb_i;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic [19:0] s_adr_o;
  logic [15:0] s_dat_o;
  logic [15:0] s_dat_i;
  logic        s_we_o;
  logic        s_byte_o;
  logic        s_stb_o;
  logic        s_ack_i;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_we_i, m0_byte_i, m0_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_dat_i, m1_we_i, m1_byte_i, m1_stb_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_byte_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_we_i, m0_byte_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_dat_i, m1_we_i, m1_byte_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_we_o, s_byte_o, s_stb_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb -- two-master arbiter in front of the memory controller.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : mem_arb_if.slave (master 0/1 ports and the controller port)
// Grant is held for a whole transaction, followed by a one-cycle release
// gap. Slave-side request signals are registered; acks, errors and read
// data back to the masters are combinational from the controller.
// A watchdog terminates a transaction that is never acknowledged with
// ack+err on the granted master.
module mem_arb #(
  parameter bit PRIO_FIXED = 1'b0, // 1: master 0 wins ties; 0: round-robin
  parameter int TO_CYCLES  = 64    // watchdog limit, 2..255
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;

  state_t     state;
  logic       last;    // last-served master
  logic [7:0] wdog;

  logic gnt0, gnt1, in_gnt, to_hit, err, done, pick1, cur_stb;

  assign gnt0    = (state == GRANT0);
  assign gnt1    = (state == GRANT1);
  assign in_gnt  = gnt0 | gnt1;
  assign to_hit  = in_gnt && (wdog == 8'(TO_CYCLES - 1));
  // A real ack in the watchdog cycle wins: it is reported as a normal ack.
  assign err     = to_hit && !bus.s_ack_i;
  assign done    = in_gnt && (bus.s_ack_i || to_hit);
  assign cur_stb = gnt0 ? bus.m0_stb_i : bus.m1_stb_i;

  // Only meaningful when at least one stb is high.
  always_comb begin
    if (PRIO_FIXED) pick1 = !bus.m0_stb_i;
    else            pick1 = bus.m1_stb_i && (!bus.m0_stb_i || !last);
  end

  assign bus.m0_ack_o = gnt0 && (bus.s_ack_i || to_hit);
  assign bus.m1_ack_o = gnt1 && (bus.s_ack_i || to_hit);
  assign bus.m0_err_o = gnt0 && err;
  assign bus.m1_err_o = gnt1 && err;
  assign bus.m0_dat_o = (gnt0 && !err) ? bus.s_dat_i : 16'h0000;
  assign bus.m1_dat_o = (gnt1 && !err) ? bus.s_dat_i : 16'h0000;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last         <= 1'b1;
      wdog         <= 8'd0;
      bus.s_stb_o  <= 1'b0;
      bus.s_adr_o  <= 20'h0;
      bus.s_dat_o  <= 16'h0;
      bus.s_we_o   <= 1'b0;
      bus.s_byte_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_stb_i || bus.m1_stb_i) begin
            bus.s_adr_o  <= pick1 ? bus.m1_adr_i  : bus.m0_adr_i;
            bus.s_dat_o  <= pick1 ? bus.m1_dat_i  : bus.m0_dat_i;
            bus.s_we_o   <= pick1 ? bus.m1_we_i   : bus.m0_we_i;
            bus.s_byte_o <= pick1 ? bus.m1_byte_i : bus.m0_byte_i;
            bus.s_stb_o  <= 1'b1;
            wdog         <= 8'd0;
            state        <= pick1 ? GRANT1 : GRANT0;
          end
        end
        GRANT0, GRANT1: begin
          // Ack, watchdog expiry and master abort all leave the same way;
          // stb must be low the cycle after ack so the controller does not
          // start a second access.
          if (done || !cur_stb) begin
            bus.s_stb_o <= 1'b0;
            last        <= gnt1;
            state       <= RELEASE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if ba();
  mem_arb_if bb();

  mem_arb #(.PRIO_FIXED(1'b0), .TO_CYCLES(8)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ba));
  mem_arb #(.PRIO_FIXED(1'b1), .TO_CYCLES(64)) dut_b (.clk_i(clk), .rst_i(rst_n), .bus(bb));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        m0_stb; logic [19:0] m0_adr; logic [15:0] m0_dat; logic m0_we; logic m0_byte;
    logic        m1_stb; logic [19:0] m1_adr; logic [15:0] m1_dat; logic m1_we; logic m1_byte;
    int          dly;  logic [15:0] rdat;
    int          gnt;  int lat;
    logic [19:0] e_adr; logic [15:0] e_dat; logic e_we; logic e_byte;
  } vec_t;

  function automatic vec_t mk(
      input logic s0, input logic [19:0] a0, input logic [15:0] d0, input logic w0, input logic b0,
      input logic s1, input logic [19:0] a1, input logic [15:0] d1, input logic w1, input logic b1,
      input int dly, input logic [15:0] rdat, input int gnt, input int lat,
      input logic [19:0] ea, input logic [15:0] ed, input logic ew, input logic eb);
    vec_t v;
    v.m0_stb = s0; v.m0_adr = a0; v.m0_dat = d0; v.m0_we = w0; v.m0_byte = b0;
    v.m1_stb = s1; v.m1_adr = a1; v.m1_dat = d1; v.m1_we = w1; v.m1_byte = b1;
    v.dly = dly; v.rdat = rdat; v.gnt = gnt; v.lat = lat;
    v.e_adr = ea; v.e_dat = ed; v.e_we = ew; v.e_byte = eb;
    return v;
  endfunction

  task automatic wait_stb_a(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ba.s_stb_o && n < 10);
  endtask

  task automatic drive_a(input vec_t v);
    ba.m0_stb_i = v.m0_stb; ba.m0_adr_i = v.m0_adr; ba.m0_dat_i = v.m0_dat;
    ba.m0_we_i = v.m0_we; ba.m0_byte_i = v.m0_byte;
    ba.m1_stb_i = v.m1_stb; ba.m1_adr_i = v.m1_adr; ba.m1_dat_i = v.m1_dat;
    ba.m1_we_i = v.m1_we; ba.m1_byte_i = v.m1_byte;
  endtask

  // One full transaction on instance A; entered and left on a negedge.
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    drive_a(v);
    wait_stb_a(n);
    chk($sformatf("v%0d_lat", idx), n, v.lat);
    for (int k = 1; k < v.dly; k++) begin
      chk($sformatf("v%0d_noack", idx), {ba.m0_ack_o, ba.m1_ack_o}, 2'b00);
      @(negedge clk);
      chk($sformatf("v%0d_hold_stb", idx), ba.s_stb_o, 1'b1);
    end
    chk($sformatf("v%0d_adr", idx), ba.s_adr_o, v.e_adr);
    chk($sformatf("v%0d_wdat", idx), ba.s_dat_o, v.e_dat);
    chk($sformatf("v%0d_we_byte", idx), {ba.s_we_o, ba.s_byte_o}, {v.e_we, v.e_byte});
    ba.s_ack_i = 1'b1;
    ba.s_dat_i = v.rdat;
    #1;
    if (v.gnt == 0) begin
      chk($sformatf("v%0d_acks", idx), {ba.m0_ack_o, ba.m1_ack_o}, 2'b10);
      chk($sformatf("v%0d_rdat", idx), ba.m0_dat_o, v.rdat);
      chk($sformatf("v%0d_other_dat", idx), ba.m1_dat_o, 16'h0000);
    end else begin
      chk($sformatf("v%0d_acks", idx), {ba.m0_ack_o, ba.m1_ack_o}, 2'b01);
      chk($sformatf("v%0d_rdat", idx), ba.m1_dat_o, v.rdat);
      chk($sformatf("v%0d_other_dat", idx), ba.m0_dat_o, 16'h0000);
    end
    chk($sformatf("v%0d_errs", idx), {ba.m0_err_o, ba.m1_err_o}, 2'b00);
    @(negedge clk);
    ba.s_ack_i = 1'b0;
    chk($sformatf("v%0d_stb_drop", idx), ba.s_stb_o, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    int n, c0, c1;
    vecs[0] = mk(1, 20'h01234, 16'h0000, 0, 0,  0, 20'h00000, 16'h0000, 0, 0,
                 5, 16'hBEEF, 0, 1, 20'h01234, 16'h0000, 0, 0);
    vecs[1] = mk(0, 20'h00000, 16'h0000, 0, 0,  1, 20'hC0001, 16'h00A5, 1, 1,
                 3, 16'h5A5A, 1, 2, 20'hC0001, 16'h00A5, 1, 1);
    vecs[2] = mk(1, 20'h00010, 16'h1111, 1, 0,  1, 20'h80020, 16'h2222, 0, 0,
                 2, 16'h3333, 0, 2, 20'h00010, 16'h1111, 1, 0);
    vecs[3] = mk(1, 20'h00012, 16'h1112, 1, 0,  1, 20'h80020, 16'h2222, 0, 0,
                 1, 16'h4444, 1, 2, 20'h80020, 16'h2222, 0, 0);
    vecs[4] = mk(1, 20'h00012, 16'h1112, 1, 0,  1, 20'h80022, 16'h2223, 0, 1,
                 2, 16'h5555, 0, 2, 20'h00012, 16'h1112, 1, 0);
    vecs[5] = mk(1, 20'h00014, 16'h1113, 1, 0,  1, 20'h80022, 16'h2223, 0, 1,
                 1, 16'h6666, 1, 2, 20'h80022, 16'h2223, 0, 1);

    ba.m0_stb_i = 0; ba.m0_adr_i = 0; ba.m0_dat_i = 0; ba.m0_we_i = 0; ba.m0_byte_i = 0;
    ba.m1_stb_i = 0; ba.m1_adr_i = 0; ba.m1_dat_i = 0; ba.m1_we_i = 0; ba.m1_byte_i = 0;
    ba.s_dat_i = 0; ba.s_ack_i = 0;
    bb.m0_stb_i = 0; bb.m0_adr_i = 0; bb.m0_dat_i = 0; bb.m0_we_i = 0; bb.m0_byte_i = 0;
    bb.m1_stb_i = 0; bb.m1_adr_i = 0; bb.m1_dat_i = 0; bb.m1_we_i = 0; bb.m1_byte_i = 0;
    bb.s_dat_i = 0; bb.s_ack_i = 0;

    // Reset state
    #12;
    chk("rst_stb", ba.s_stb_o, 1'b0);
    chk("rst_adr", ba.s_adr_o, 20'h0);
    chk("rst_dat", ba.s_dat_o, 16'h0);
    chk("rst_we_byte", {ba.s_we_o, ba.s_byte_o}, 2'b00);
    chk("rst_b_stb", bb.s_stb_o, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: single read, byte write, then round-robin with both held
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    ba.m0_stb_i = 0; ba.m1_stb_i = 0;
    repeat (3) @(negedge clk);

    // Late ack in IDLE is ignored
    ba.s_ack_i = 1'b1;
    #1;
    chk("late_ack", {ba.m0_ack_o, ba.m1_ack_o, ba.m0_err_o, ba.m1_err_o}, 4'b0000);
    @(negedge clk);
    ba.s_ack_i = 1'b0;
    chk("late_ack_stb", ba.s_stb_o, 1'b0);

    // Watchdog: m0 (m1 served last) never acked, m1 pending behind it
    ba.s_dat_i = 16'hDEAD;
    ba.m0_adr_i = 20'h00ABC; ba.m0_we_i = 0; ba.m0_stb_i = 1;
    ba.m1_adr_i = 20'h80ABC; ba.m1_we_i = 0; ba.m1_byte_i = 0; ba.m1_stb_i = 1;
    wait_stb_a(n);
    chk("wd_stb", ba.s_stb_o, 1'b1);
    chk("wd_adr", ba.s_adr_o, 20'h00ABC);
    n = 1;
    while (n < 8) begin
      chk("wd_early", {ba.m0_ack_o, ba.m0_err_o}, 2'b00);
      @(negedge clk);
      n++;
    end
    #1;
    chk("wd_ack_err", {ba.m0_ack_o, ba.m0_err_o}, 2'b11);
    chk("wd_dat", ba.m0_dat_o, 16'h0000);
    chk("wd_m1_ack", ba.m1_ack_o, 1'b0);
    ba.m0_stb_i = 0;
    @(negedge clk);
    chk("wd_stb_drop", ba.s_stb_o, 1'b0);
    wait_stb_a(n);
    chk("wd_m1_adr", ba.s_adr_o, 20'h80ABC);
    ba.s_ack_i = 1; ba.s_dat_i = 16'h7777;
    #1;
    chk("wd_m1_ack_err", {ba.m1_ack_o, ba.m1_err_o}, 2'b10);
    chk("wd_m1_dat", ba.m1_dat_o, 16'h7777);
    @(negedge clk);
    ba.s_ack_i = 0; ba.m1_stb_i = 0;
    repeat (2) @(negedge clk);

    // Master abort: m0 drops stb; last-served still moves to m0
    ba.m0_adr_i = 20'h00100; ba.m0_stb_i = 1;
    wait_stb_a(n);
    chk("ab_adr", ba.s_adr_o, 20'h00100);
    ba.m0_stb_i = 0;
    #1;
    chk("ab_noack", ba.m0_ack_o, 1'b0);
    @(negedge clk);
    chk("ab_stb_drop", ba.s_stb_o, 1'b0);
    chk("ab_noack2", ba.m0_ack_o, 1'b0);
    repeat (2) @(negedge clk);
    ba.m0_adr_i = 20'h00200; ba.m0_stb_i = 1;
    ba.m1_adr_i = 20'h80200; ba.m1_stb_i = 1;
    wait_stb_a(n);
    chk("ab_next_m1", ba.s_adr_o, 20'h80200);
    ba.s_ack_i = 1;
    #1;
    chk("ab_next_ack", {ba.m0_ack_o, ba.m1_ack_o}, 2'b01);
    @(negedge clk);
    ba.s_ack_i = 0; ba.m0_stb_i = 0; ba.m1_stb_i = 0;
    repeat (2) @(negedge clk);

    // Reset during GRANT1: stb drops with no clock edge, no ack/err
    ba.m1_adr_i = 20'h80300; ba.m1_stb_i = 1;
    wait_stb_a(n);
    chk("rg_stb", ba.s_stb_o, 1'b1);
    #2;
    ba.s_ack_i = 1;
    rst_n = 1'b0;
    #1;
    chk("rg_stb_async", ba.s_stb_o, 1'b0);
    chk("rg_adr", ba.s_adr_o, 20'h0);
    chk("rg_ack_err", {ba.m1_ack_o, ba.m1_err_o, ba.m0_ack_o}, 3'b000);
    ba.m1_stb_i = 0;
    @(negedge clk);
    ba.s_ack_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ba.m0_adr_i = 20'h00400; ba.m0_stb_i = 1;
    ba.m1_adr_i = 20'h80400; ba.m1_stb_i = 1;
    wait_stb_a(n);
    chk("rg_lat", n, 1);
    chk("rg_m0_first", ba.s_adr_o, 20'h00400);
    ba.s_ack_i = 1;
    #1;
    chk("rg_ack", {ba.m0_ack_o, ba.m1_ack_o}, 2'b10);
    @(negedge clk);
    ba.s_ack_i = 0; ba.m0_stb_i = 0; ba.m1_stb_i = 0;

    // Fixed priority instance: both held, m0 always wins
    bb.m0_adr_i = 20'h00001; bb.m0_stb_i = 1;
    bb.m1_adr_i = 20'h80001; bb.m1_stb_i = 1;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 60 && (c0 + c1) < 4; k++) begin
      @(negedge clk);
      if (bb.s_ack_i) bb.s_ack_i = 0;
      else if (bb.s_stb_o) begin
        bb.s_ack_i = 1;
        #1;
        if (bb.m0_ack_o) c0++;
        if (bb.m1_ack_o) c1++;
      end
    end
    chk("fix_m0_count", c0, 4);
    chk("fix_m1_count", c1, 0);
    @(negedge clk);
    bb.s_ack_i = 0; bb.m0_stb_i = 0; bb.m1_stb_i = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
